// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline control blocks.
//   state_e    : stall controller FSM states
//   REG_ADDR_W : architectural register index width
//   X0         : hard-wired zero register, never a hazard source
//   id_src_t   : source-operand bundle of the instruction in ID
//   rd_hits()  : does a destination register feed a used source operand
package pipe_ctrl_pkg;

   localparam int REG_ADDR_W = 5;
   localparam logic [REG_ADDR_W-1:0] X0 = '0;

   typedef enum logic {
      RUN      = 1'b0,
      MEM_WAIT = 1'b1
   } state_e;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] rs1;
      logic [REG_ADDR_W-1:0] rs2;
      logic                  use_rs1;
      logic                  use_rs2;
   } id_src_t;

   // x0 always reads as zero, so writes to it never create a dependency.
   function automatic logic rd_hits(input logic [REG_ADDR_W-1:0] rd,
                                    input logic [REG_ADDR_W-1:0] src,
                                    input logic                  use_src);
      return use_src && (rd != X0) && (rd == src);
   endfunction

endpackage

// File: rtl/hazard_compare.sv
// Combinational load-use detector.
//   id_src      : rs1/rs2 and their use flags for the instruction in ID
//   ex_rd       : destination register of the instruction in EX
//   ex_mem_read : instruction in EX is a load
//   load_use    : ID consumes the load result before it can be forwarded
module hazard_compare
   import pipe_ctrl_pkg::*;
(
   input  id_src_t               id_src,
   input  logic [REG_ADDR_W-1:0] ex_rd,
   input  logic                  ex_mem_read,
   output logic                  load_use
);

   logic hit_rs1;
   logic hit_rs2;

   assign hit_rs1  = rd_hits(ex_rd, id_src.rs1, id_src.use_rs1);
   assign hit_rs2  = rd_hits(ex_rd, id_src.rs2, id_src.use_rs2);
   assign load_use = ex_mem_read & (hit_rs1 | hit_rs2);

endmodule

// File: rtl/hazard_stall_controller.sv
// Stall / flush controller for the 5-stage pipeline. Covers the hazards the
// EX forwarding network cannot: load-use in ID, data-memory wait states, and
// IF/ID flushes for branches resolved taken in ID.
//   clk_i, rst_i           : clock, async active-low reset
//   IF_ID_Rs*/UseRs*       : source operands of the instruction in ID
//   ID_EX_Rd_i/MemRead_i   : destination / load flag of the instruction in EX
//   Branch_Taken_i         : branch in ID resolved taken
//   dmem_req_i/ready_i     : data-memory access handshake
//   PCWrite_o, IF_ID_Write_o, ID_EX_Bubble_o, IF_ID_Flush_o, Pipe_Hold_o :
//                            pipeline register controls (combinational)
//   stall_cnt_o            : saturating count of cycles with PC frozen
//   err_o                  : sticky memory-wait protocol/timeout error
module hazard_stall_controller
   import pipe_ctrl_pkg::*;
#(
   parameter int CNT_W    = 16,
   parameter int MAX_WAIT = 64
)(
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [REG_ADDR_W-1:0] IF_ID_Rs1_i,
   input  logic [REG_ADDR_W-1:0] IF_ID_Rs2_i,
   input  logic                  IF_ID_UseRs1_i,
   input  logic                  IF_ID_UseRs2_i,
   input  logic [REG_ADDR_W-1:0] ID_EX_Rd_i,
   input  logic                  ID_EX_MemRead_i,
   input  logic                  Branch_Taken_i,
   input  logic                  dmem_req_i,
   input  logic                  dmem_ready_i,
   output logic                  PCWrite_o,
   output logic                  IF_ID_Write_o,
   output logic                  ID_EX_Bubble_o,
   output logic                  IF_ID_Flush_o,
   output logic                  Pipe_Hold_o,
   output logic [CNT_W-1:0]      stall_cnt_o,
   output logic                  err_o
);

   localparam int          WAIT_W     = $clog2(MAX_WAIT + 1);
   // wait_cnt trails the number of frozen cycles by one (the RUN cycle that
   // starts the access is frozen but not counted), so the timeout fires when
   // the incremented count would reach MAX_WAIT-1, i.e. after MAX_WAIT
   // frozen cycles in total.
   localparam logic [31:0] TIMEOUT_AT = 32'(MAX_WAIT - 1);

   state_e              state, state_nxt;
   logic [WAIT_W-1:0]   wait_cnt, wait_nxt;
   logic                pend_flush;
   logic                err_set;
   logic                mem_stall;
   logic                freeze;
   logic                load_use;
   logic                flush_take;
   logic                wait_last;
   id_src_t             id_src;

   assign id_src = '{rs1:     IF_ID_Rs1_i,
                     rs2:     IF_ID_Rs2_i,
                     use_rs1: IF_ID_UseRs1_i,
                     use_rs2: IF_ID_UseRs2_i};

   hazard_compare u_hazard_compare (
      .id_src      (id_src),
      .ex_rd       (ID_EX_Rd_i),
      .ex_mem_read (ID_EX_MemRead_i),
      .load_use    (load_use)
   );

   assign mem_stall = dmem_req_i & ~dmem_ready_i;
   assign freeze    = (state == MEM_WAIT) | mem_stall;
   assign wait_last = (32'(wait_cnt) + 32'd1) >= TIMEOUT_AT;

   // ---------------- next state / wait counter ----------------
   always_comb begin
      state_nxt = state;
      wait_nxt  = wait_cnt;
      err_set   = 1'b0;
      case (state)
         RUN: begin
            if (mem_stall) state_nxt = MEM_WAIT;
         end
         MEM_WAIT: begin
            if (dmem_ready_i) begin
               state_nxt = RUN;
               wait_nxt  = '0;
            end else if (!dmem_req_i) begin
               // request withdrawn without completion: protocol error
               state_nxt = RUN;
               wait_nxt  = '0;
               err_set   = 1'b1;
            end else if (wait_last) begin
               state_nxt = RUN;
               wait_nxt  = '0;
               err_set   = 1'b1;
            end else begin
               wait_nxt  = wait_cnt + 1'b1;
            end
         end
         default: begin
            state_nxt = RUN;
            wait_nxt  = '0;
         end
      endcase
   end

   // ---------------- output mux ----------------
   // Reset forces the "free running" encoding even if the inputs would
   // otherwise request a stall.
   always_comb begin
      PCWrite_o      = 1'b1;
      IF_ID_Write_o  = 1'b1;
      ID_EX_Bubble_o = 1'b0;
      IF_ID_Flush_o  = 1'b0;
      Pipe_Hold_o    = 1'b0;
      flush_take     = 1'b0;
      if (rst_i) begin
         if (freeze) begin
            PCWrite_o      = 1'b0;
            IF_ID_Write_o  = 1'b0;
            Pipe_Hold_o    = 1'b1;
         end else if (load_use) begin
            // branch operands are stale behind a load; let it re-resolve
            PCWrite_o      = 1'b0;
            IF_ID_Write_o  = 1'b0;
            ID_EX_Bubble_o = 1'b1;
         end else if (Branch_Taken_i | pend_flush) begin
            IF_ID_Flush_o  = 1'b1;
            flush_take     = 1'b1;
         end
      end
   end

   // ---------------- state registers ----------------
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state    <= RUN;
         wait_cnt <= '0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_nxt;
      end
   end

   // A branch taken while frozen cannot flush (IF/ID is held), so remember
   // it until the first cycle where a flush can actually take effect.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i)          pend_flush <= 1'b0;
      else if (freeze)     pend_flush <= pend_flush | Branch_Taken_i;
      else if (flush_take) pend_flush <= 1'b0;
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i)       err_o <= 1'b0;
      else if (err_set) err_o <= 1'b1;
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i)
         stall_cnt_o <= '0;
      else if (!PCWrite_o && (stall_cnt_o != '1))
         stall_cnt_o <= stall_cnt_o + 1'b1;
   end

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Self-checking bench for hazard_stall_controller: directed scenarios pinned
// with literal expectations, then randomized traffic checked every cycle
// against a behavioural model, then a long forced stall for saturation.
module tb_hazard_stall_controller;

   localparam int CNT_W    = 16;
   localparam int MAX_WAIT = 4;
   localparam int CNT_MAX  = (1 << CNT_W) - 1;

   logic             clk_i = 1'b0;
   logic             rst_i = 1'b0;
   logic [4:0]       IF_ID_Rs1_i = '0, IF_ID_Rs2_i = '0, ID_EX_Rd_i = '0;
   logic             IF_ID_UseRs1_i = 0, IF_ID_UseRs2_i = 0, ID_EX_MemRead_i = 0;
   logic             Branch_Taken_i = 0, dmem_req_i = 0, dmem_ready_i = 0;
   logic             PCWrite_o, IF_ID_Write_o, ID_EX_Bubble_o, IF_ID_Flush_o, Pipe_Hold_o;
   logic [CNT_W-1:0] stall_cnt_o;
   logic             err_o;

   hazard_stall_controller #(.CNT_W(CNT_W), .MAX_WAIT(MAX_WAIT)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .IF_ID_Rs1_i(IF_ID_Rs1_i), .IF_ID_Rs2_i(IF_ID_Rs2_i),
      .IF_ID_UseRs1_i(IF_ID_UseRs1_i), .IF_ID_UseRs2_i(IF_ID_UseRs2_i),
      .ID_EX_Rd_i(ID_EX_Rd_i), .ID_EX_MemRead_i(ID_EX_MemRead_i),
      .Branch_Taken_i(Branch_Taken_i), .dmem_req_i(dmem_req_i), .dmem_ready_i(dmem_ready_i),
      .PCWrite_o(PCWrite_o), .IF_ID_Write_o(IF_ID_Write_o), .ID_EX_Bubble_o(ID_EX_Bubble_o),
      .IF_ID_Flush_o(IF_ID_Flush_o), .Pipe_Hold_o(Pipe_Hold_o),
      .stall_cnt_o(stall_cnt_o), .err_o(err_o)
   );

   always #5 clk_i = ~clk_i;

   int errors = 0;
   int checks = 0;

   // model: frozen cycles in the current memory access (0 = no access open)
   int m_acc;
   bit m_pend, m_err;
   int m_stalls;

   // last values sampled by cyc()
   logic s_pc, s_ifw, s_bub, s_flush, s_hold, s_err;
   logic [CNT_W-1:0] s_cnt;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_acc = 0; m_pend = 0; m_err = 0; m_stalls = 0;
   endtask

   task automatic idle();
      IF_ID_Rs1_i = '0; IF_ID_Rs2_i = '0; ID_EX_Rd_i = '0;
      IF_ID_UseRs1_i = 0; IF_ID_UseRs2_i = 0; ID_EX_MemRead_i = 0;
      Branch_Taken_i = 0; dmem_req_i = 0; dmem_ready_i = 0;
   endtask

   function automatic void model_outs(output bit pc, output bit ifw, output bit bub,
                                      output bit fl, output bit hold,
                                      output bit frz, output bit lu);
      frz = (m_acc > 0) || (dmem_req_i && !dmem_ready_i);
      lu  = ID_EX_MemRead_i && (ID_EX_Rd_i != 0) &&
            ((IF_ID_UseRs1_i && ID_EX_Rd_i == IF_ID_Rs1_i) ||
             (IF_ID_UseRs2_i && ID_EX_Rd_i == IF_ID_Rs2_i));
      pc = 1; ifw = 1; bub = 0; fl = 0; hold = 0;
      if (frz)                          begin pc = 0; ifw = 0; hold = 1; end
      else if (lu)                      begin pc = 0; ifw = 0; bub = 1; end
      else if (Branch_Taken_i || m_pend) fl = 1;
   endfunction

   // One clock cycle with the currently driven inputs: compare outputs to the
   // model mid-cycle, then advance the model across the rising edge.
   task automatic cyc();
      bit pc, ifw, bub, fl, hold, frz, lu;
      @(negedge clk_i);
      model_outs(pc, ifw, bub, fl, hold, frz, lu);
      s_pc = PCWrite_o; s_ifw = IF_ID_Write_o; s_bub = ID_EX_Bubble_o;
      s_flush = IF_ID_Flush_o; s_hold = Pipe_Hold_o; s_cnt = stall_cnt_o; s_err = err_o;
      chk("PCWrite",    32'(PCWrite_o),      32'(pc));
      chk("IF_ID_Write",32'(IF_ID_Write_o),  32'(ifw));
      chk("Bubble",     32'(ID_EX_Bubble_o), 32'(bub));
      chk("Flush",      32'(IF_ID_Flush_o),  32'(fl));
      chk("Hold",       32'(Pipe_Hold_o),    32'(hold));
      chk("stall_cnt",  32'(stall_cnt_o),    32'(m_stalls));
      chk("err",        32'(err_o),          32'(m_err));
      @(posedge clk_i);
      if (!pc && m_stalls < CNT_MAX) m_stalls++;
      if (frz)      m_pend = m_pend | Branch_Taken_i;
      else if (!lu) m_pend = 0;
      if (frz) begin
         if (dmem_ready_i) m_acc = 0;
         else if (m_acc > 0 && !dmem_req_i) begin m_err = 1; m_acc = 0; end
         else begin
            m_acc++;
            if (m_acc >= MAX_WAIT) begin m_err = 1; m_acc = 0; end
         end
      end
      #1;
   endtask

   // Asynchronous reset asserted mid-cycle with whatever inputs are driven.
   task automatic do_reset(input string tag);
      @(negedge clk_i); #2;
      rst_i = 1'b0;
      #1;
      chk({tag, "_rst_pc"},   32'(PCWrite_o),      32'd1);
      chk({tag, "_rst_ifw"},  32'(IF_ID_Write_o),  32'd1);
      chk({tag, "_rst_hold"}, 32'(Pipe_Hold_o),    32'd0);
      chk({tag, "_rst_bub"},  32'(ID_EX_Bubble_o), 32'd0);
      chk({tag, "_rst_cnt"},  32'(stall_cnt_o),    32'd0);
      chk({tag, "_rst_err"},  32'(err_o),          32'd0);
      model_reset();
      idle();
      @(posedge clk_i); #1;
      rst_i = 1'b1;
   endtask

   initial begin
      int holds;
      model_reset();
      // inputs requesting every kind of stall while in reset
      dmem_req_i = 1; ID_EX_MemRead_i = 1; ID_EX_Rd_i = 5'd5;
      IF_ID_Rs1_i = 5'd5; IF_ID_UseRs1_i = 1; Branch_Taken_i = 1;
      do_reset("init");

      // load-use on rs1: one bubble, then normal
      ID_EX_MemRead_i = 1; ID_EX_Rd_i = 5'd5; IF_ID_Rs1_i = 5'd5; IF_ID_UseRs1_i = 1;
      cyc();
      chk("lu_bubble", 32'(s_bub), 32'd1);
      chk("lu_pc",     32'(s_pc),  32'd0);
      ID_EX_MemRead_i = 0;
      cyc();
      chk("lu_after_pc", 32'(s_pc),  32'd1);
      chk("lu_cnt",      32'(s_cnt), 32'd1);

      // x0 and unused rs2 are not hazards
      idle(); ID_EX_MemRead_i = 1; ID_EX_Rd_i = 0; IF_ID_Rs1_i = 0; IF_ID_UseRs1_i = 1;
      cyc();
      chk("x0_nostall", 32'(s_pc), 32'd1);
      idle(); ID_EX_MemRead_i = 1; ID_EX_Rd_i = 5'd7; IF_ID_Rs2_i = 5'd7;
      cyc();
      chk("rs2_unused_nostall", 32'(s_pc), 32'd1);

      // memory wait 3 cycles + ready cycle, branch during 2nd frozen cycle
      do_reset("mw");
      holds = 0;
      dmem_req_i = 1;
      for (int i = 0; i < 3; i++) begin
         Branch_Taken_i = (i == 1);
         cyc();
         holds += int'(s_hold);
         chk("mw_noflush", 32'(s_flush), 32'd0);
      end
      Branch_Taken_i = 0; dmem_ready_i = 1;
      cyc();
      holds += int'(s_hold);
      chk("mw_noflush_last", 32'(s_flush), 32'd0);
      idle();
      cyc();
      chk("mw_holds",      32'(holds),   32'd4);
      chk("mw_run",        32'(s_hold),  32'd0);
      chk("mw_cnt",        32'(s_cnt),   32'd4);
      chk("mw_pend_flush", 32'(s_flush), 32'd1);
      cyc();
      chk("mw_flush_clear", 32'(s_flush), 32'd0);

      // timeout after MAX_WAIT frozen cycles, err sticky, then reset mid-wait
      do_reset("to");
      dmem_req_i = 1;
      for (int i = 0; i < MAX_WAIT; i++) cyc();
      chk("to_err_before", 32'(s_err), 32'd0);
      dmem_req_i = 0;
      cyc();
      chk("to_err",  32'(s_err),  32'd1);
      chk("to_run",  32'(s_hold), 32'd0);
      cyc();
      chk("to_err_sticky", 32'(s_err), 32'd1);
      dmem_req_i = 1;
      cyc(); cyc();
      do_reset("midwait");

      // load-use beats a taken branch; branch resolves next cycle
      ID_EX_MemRead_i = 1; ID_EX_Rd_i = 5'd3; IF_ID_Rs2_i = 5'd3; IF_ID_UseRs2_i = 1;
      Branch_Taken_i = 1;
      cyc();
      chk("lu_br_bubble",  32'(s_bub),   32'd1);
      chk("lu_br_noflush", 32'(s_flush), 32'd0);
      ID_EX_MemRead_i = 0;
      cyc();
      chk("lu_br_flush", 32'(s_flush), 32'd1);
      idle();
      cyc();

      // randomized traffic, small register space to make hits frequent
      for (int i = 0; i < 3000; i++) begin
         IF_ID_Rs1_i     = 5'($urandom_range(0, 3));
         IF_ID_Rs2_i     = 5'($urandom_range(0, 3));
         ID_EX_Rd_i      = 5'($urandom_range(0, 3));
         IF_ID_UseRs1_i  = 1'($urandom_range(0, 1));
         IF_ID_UseRs2_i  = 1'($urandom_range(0, 1));
         ID_EX_MemRead_i = ($urandom_range(0, 3) == 0);
         Branch_Taken_i  = ($urandom_range(0, 4) == 0);
         if (m_acc > 0) begin
            dmem_req_i   = ($urandom_range(0, 15) != 0);
            dmem_ready_i = ($urandom_range(0, 3) == 0);
         end else begin
            dmem_req_i   = ($urandom_range(0, 5) == 0);
            dmem_ready_i = ($urandom_range(0, 1) == 0);
         end
         cyc();
         if (i == 1500) do_reset("rand");
      end

      // saturation under a permanently stalled memory
      do_reset("sat");
      dmem_req_i = 1;
      for (int i = 0; i < CNT_MAX + 8; i++) cyc();
      chk("sat_cnt", 32'(s_cnt), 32'hFFFF);
      cyc();
      chk("sat_nowrap", 32'(s_cnt), 32'hFFFF);
      idle();
      cyc();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
